// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command path: FSM state encodings and frame geometry.
package uart_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_COMMIT = 3'd4
    } cmd_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    // ADDR + data bytes + CSUM following the SYNC marker
    localparam int FRAME_BYTES = 6;
    localparam int DATA_BYTES  = FRAME_BYTES - 2;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-in / register-write-out bundle between uart_rx, the command controller and the register file.
interface uart_cmd_ctrl_if;

    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic        o_Wr_En;
    logic [7:0]  o_Wr_Addr;
    logic [31:0] o_Wr_Data;
    logic        o_Frame_Err;
    logic        o_Busy;
    logic [7:0]  o_Err_Count;

    modport master (
        output i_Rx_DV, i_Rx_Byte,
        input  o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Err, o_Busy, o_Err_Count
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte,
        output o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Err, o_Busy, o_Err_Count
    );

endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte watchdog: counts while enabled, clears on demand, flags the last allowed cycle.
module uart_cmd_timer #(
    parameter int CNT_W        = 16,
    parameter int TIMEOUT_CLKS = 47240
) (
    input  logic osc_clk,
    input  logic arst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge osc_clk or posedge arst) begin
        if (arst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == CNT_W'(TIMEOUT_CLKS - 1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames SYNC/ADDR/D3..D0/CSUM byte streams from uart_rx into register-write strobes,
// dropping frames with a bad checksum or a stalled byte stream.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = 47240,
    parameter int         CNT_W        = 16
) (
    input  logic           osc_clk,
    input  logic           arst,
    uart_cmd_ctrl_if.slave bus
);

    cmd_state_e  state;
    logic [7:0]  addr_sh;
    logic [31:0] data_sh;
    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_err;
    logic [7:0]  err_count;

    logic        in_frame;
    logic        expire;
    logic        rx_dv;
    logic [7:0]  rx_byte;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign rx_dv    = bus.i_Rx_DV;
    assign rx_byte  = bus.i_Rx_Byte;
    assign in_frame = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CSUM);

    // Timer only runs mid-frame; expiry also clears it so it restarts from 0 in IDLE.
    uart_cmd_timer #(
        .CNT_W        (CNT_W),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timer (
        .osc_clk (osc_clk),
        .arst    (arst),
        .clr     (!in_frame || rx_dv || expire),
        .en      (in_frame),
        .expire  (expire)
    );

    always_ff @(posedge osc_clk or posedge arst) begin
        if (arst) begin
            state     <= ST_IDLE;
            addr_sh   <= '0;
            data_sh   <= '0;
            csum      <= '0;
            byte_idx  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                // COMMIT treats its byte like IDLE so a back-to-back SYNC is not lost
                ST_IDLE, ST_COMMIT: begin
                    if (rx_dv && (rx_byte == SYNC_BYTE)) begin
                        csum  <= '0;
                        state <= ST_ADDR;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (rx_dv) begin
                        addr_sh  <= rx_byte;
                        csum     <= rx_byte;
                        byte_idx <= '0;
                        state    <= ST_DATA;
                    end else if (expire) begin
                        frame_err <= 1'b1;
                        err_count <= sat_inc(err_count);
                        state     <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (rx_dv) begin
                        data_sh <= {data_sh[23:0], rx_byte};
                        csum    <= csum ^ rx_byte;
                        if (byte_idx == 2'(DATA_BYTES - 1)) begin
                            state <= ST_CSUM;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end else if (expire) begin
                        frame_err <= 1'b1;
                        err_count <= sat_inc(err_count);
                        state     <= ST_IDLE;
                    end
                end
                ST_CSUM: begin
                    if (rx_dv) begin
                        if (rx_byte == csum) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr_sh;
                            wr_data <= data_sh;
                            state   <= ST_COMMIT;
                        end else begin
                            frame_err <= 1'b1;
                            err_count <= sat_inc(err_count);
                            state     <= ST_IDLE;
                        end
                    end else if (expire) begin
                        frame_err <= 1'b1;
                        err_count <= sat_inc(err_count);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_Wr_En     = wr_en;
    assign bus.o_Wr_Addr   = wr_addr;
    assign bus.o_Wr_Data   = wr_data;
    assign bus.o_Frame_Err = frame_err;
    assign bus.o_Err_Count = err_count;
    assign bus.o_Busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: good/bad frames, timeout, resync, reset and error saturation.
module tb_uart_cmd_ctrl;

    localparam int T_OUT = 200;

    logic osc_clk;
    logic arst;
    int   n_checks;
    int   n_errors;
    int   wr_pulses;
    int   err_pulses;
    int   wr_mark;
    int   err_mark;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (T_OUT),
        .CNT_W        (8)
    ) dut (
        .osc_clk (osc_clk),
        .arst    (arst),
        .bus     (bus)
    );

    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    always @(negedge osc_clk) begin
        if (bus.o_Wr_En === 1'b1)     wr_pulses  <= wr_pulses + 1;
        if (bus.o_Frame_Err === 1'b1) err_pulses <= err_pulses + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge osc_clk);
        #1;
    endtask

    // Drives one DV cycle; consecutive calls give DV on consecutive cycles.
    task automatic send_byte(input logic [7:0] b);
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        @(posedge osc_clk);
        #1;
        bus.i_Rx_DV   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d[31:24]);
        send_byte(d[23:16]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        send_byte(cs);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        wr_pulses     = 0;
        err_pulses    = 0;
        arst          = 1'b1;
        bus.i_Rx_DV   = 1'b0;
        bus.i_Rx_Byte = 8'h00;

        // reset state
        tick(3);
        check_val("rst_wr_en",  {31'd0, bus.o_Wr_En}, 32'd0);
        check_val("rst_addr",   {24'd0, bus.o_Wr_Addr}, 32'd0);
        check_val("rst_data",   bus.o_Wr_Data, 32'd0);
        check_val("rst_err",    {31'd0, bus.o_Frame_Err}, 32'd0);
        check_val("rst_busy",   {31'd0, bus.o_Busy}, 32'd0);
        check_val("rst_errcnt", {24'd0, bus.o_Err_Count}, 32'd0);
        arst = 1'b0;
        tick(2);

        // good frame, 1-clk strobe latency
        wr_mark = wr_pulses; err_mark = err_pulses;
        send_byte(8'hA5); send_byte(8'h10);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        check_val("good_busy_mid", {31'd0, bus.o_Busy}, 32'd1);
        check_val("good_pre_wr",   {31'd0, bus.o_Wr_En}, 32'd0);
        send_byte(8'h32);
        check_val("good_wr_en", {31'd0, bus.o_Wr_En}, 32'd1);
        check_val("good_addr",  {24'd0, bus.o_Wr_Addr}, 32'h10);
        check_val("good_data",  bus.o_Wr_Data, 32'hDEADBEEF);
        tick(1);
        check_val("good_wr_drop", {31'd0, bus.o_Wr_En}, 32'd0);
        check_val("good_idle",    {31'd0, bus.o_Busy}, 32'd0);
        check_val("good_pulses",  wr_pulses - wr_mark, 32'd1);
        check_val("good_no_err",  err_pulses - err_mark, 32'd0);

        // bad checksums leave the write outputs untouched
        wr_mark = wr_pulses;
        send_frame(8'h10, 32'hDEADBEEF, 8'h33);
        check_val("bad_err",    {31'd0, bus.o_Frame_Err}, 32'd1);
        check_val("bad_errcnt", {24'd0, bus.o_Err_Count}, 32'd1);
        check_val("bad_busy",   {31'd0, bus.o_Busy}, 32'd0);
        send_frame(8'h77, 32'h01020304, 8'h00);
        check_val("bad2_errcnt", {24'd0, bus.o_Err_Count}, 32'd2);
        check_val("bad2_addr",   {24'd0, bus.o_Wr_Addr}, 32'h10);
        check_val("bad2_data",   bus.o_Wr_Data, 32'hDEADBEEF);
        tick(1);
        check_val("bad_err_drop", {31'd0, bus.o_Frame_Err}, 32'd0);
        check_val("bad_no_wr",    wr_pulses - wr_mark, 32'd0);

        // timeout: error registered T_OUT edges after the last DV edge
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'hDE);
        tick(T_OUT - 1);
        check_val("to_not_yet", {31'd0, bus.o_Frame_Err}, 32'd0);
        check_val("to_busy",    {31'd0, bus.o_Busy}, 32'd1);
        tick(1);
        check_val("to_err",     {31'd0, bus.o_Frame_Err}, 32'd1);
        check_val("to_idle",    {31'd0, bus.o_Busy}, 32'd0);
        check_val("to_errcnt",  {24'd0, bus.o_Err_Count}, 32'd3);
        tick(2);
        send_frame(8'h20, 32'h01020304, 8'h24);
        check_val("to_next_wr",   {31'd0, bus.o_Wr_En}, 32'd1);
        check_val("to_next_addr", {24'd0, bus.o_Wr_Addr}, 32'h20);
        check_val("to_next_data", bus.o_Wr_Data, 32'h01020304);
        tick(1);

        // DV in the expiry cycle wins over the timeout
        err_mark = err_pulses;
        send_byte(8'hA5); send_byte(8'h10);
        tick(T_OUT - 1);
        send_byte(8'hDE);
        check_val("race_no_err", {31'd0, bus.o_Frame_Err}, 32'd0);
        check_val("race_busy",   {31'd0, bus.o_Busy}, 32'd1);
        send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h32);
        check_val("race_wr", {31'd0, bus.o_Wr_En}, 32'd1);
        tick(1);
        check_val("race_err_pulses", err_pulses - err_mark, 32'd0);
        check_val("race_errcnt", {24'd0, bus.o_Err_Count}, 32'd3);

        // junk ignored, SYNC as payload, SYNC during COMMIT starts the next frame
        wr_mark = wr_pulses; err_mark = err_pulses;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check_val("junk_idle", {31'd0, bus.o_Busy}, 32'd0);
        send_frame(8'h30, 32'h11223344, 8'h74);
        check_val("rs1_wr",   {31'd0, bus.o_Wr_En}, 32'd1);
        check_val("rs1_addr", {24'd0, bus.o_Wr_Addr}, 32'h30);
        send_frame(8'h40, 32'hA5BBCCDD, 8'h4F);
        check_val("rs2_wr",   {31'd0, bus.o_Wr_En}, 32'd1);
        check_val("rs2_addr", {24'd0, bus.o_Wr_Addr}, 32'h40);
        check_val("rs2_data", bus.o_Wr_Data, 32'hA5BBCCDD);
        tick(1);
        check_val("rs_pulses", wr_pulses - wr_mark, 32'd2);
        check_val("rs_no_err", err_pulses - err_mark, 32'd0);

        // asynchronous reset mid-frame
        wr_mark = wr_pulses; err_mark = err_pulses;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'hDE); send_byte(8'hAD);
        #2;
        arst = 1'b1;
        #1;
        check_val("mid_rst_busy",   {31'd0, bus.o_Busy}, 32'd0);
        check_val("mid_rst_addr",   {24'd0, bus.o_Wr_Addr}, 32'd0);
        check_val("mid_rst_data",   bus.o_Wr_Data, 32'd0);
        check_val("mid_rst_errcnt", {24'd0, bus.o_Err_Count}, 32'd0);
        tick(2);
        arst = 1'b0;
        tick(1);
        check_val("mid_rst_no_wr",  wr_pulses - wr_mark, 32'd0);
        check_val("mid_rst_no_err", err_pulses - err_mark, 32'd0);
        send_frame(8'h10, 32'hDEADBEEF, 8'h32);
        check_val("post_rst_wr",   {31'd0, bus.o_Wr_En}, 32'd1);
        check_val("post_rst_data", bus.o_Wr_Data, 32'hDEADBEEF);
        tick(1);

        // error counter saturation
        wr_mark = wr_pulses; err_mark = err_pulses;
        for (int i = 0; i < 260; i++) begin
            send_frame(8'h10, 32'hDEADBEEF, 8'h33);
            if (i == 253) check_val("sat_254", {24'd0, bus.o_Err_Count}, 32'hFE);
            if (i == 254) check_val("sat_255", {24'd0, bus.o_Err_Count}, 32'hFF);
        end
        check_val("sat_260",    {24'd0, bus.o_Err_Count}, 32'hFF);
        tick(1);
        check_val("sat_pulses", err_pulses - err_mark, 32'd260);
        check_val("sat_no_wr",  wr_pulses - wr_mark, 32'd0);
        check_val("sat_addr",   {24'd0, bus.o_Wr_Addr}, 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
